// File: rtl/fanout_bcast_pkg.sv
// Shared types and sizing helpers for the broadcast fanout controller.
package fanout_bcast_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH   = 1;
  localparam int unsigned DEF_NUM_GRP = 2;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 16;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fanout_bcast_ctrl_grp_reg.sv
// Per-group repeater flop: a private copy of the broadcast word plus its strobe.
module bcast_grp_reg
  import fanout_bcast_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Capture on load, otherwise hold; strobe is a one-cycle echo of load.
  always_comb begin
    data_d  = load ? d : data_q;
    valid_d = load;
  end

  // Repeater registers with synchronous reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/fanout_bcast_ctrl.sv
// Broadcast driver: accepts one word, replicates it into per-group flops,
// then waits for every group to acknowledge or for the timeout to expire.
module fanout_bcast_ctrl
  import fanout_bcast_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_GRP = DEF_NUM_GRP,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic [NUM_GRP-1:0]       grp_valid,
  output logic [NUM_GRP*WIDTH-1:0] grp_data,
  input  logic [NUM_GRP-1:0]       grp_ack,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [NUM_GRP-1:0]       timeout_grp,
  output logic [CNT_W-1:0]         bcast_count
);

  localparam int unsigned TCW = clog2(TIMEOUT);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [NUM_GRP-1:0] pend_q, pend_d, pend_nxt;
  logic [TCW-1:0]     tcnt_q, tcnt_d;
  logic               err_q, err_d;
  logic [NUM_GRP-1:0] tgrp_q, tgrp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;
  logic               accept;

  // Ready is registered from the next state and forced low while rst is held.
  assign in_ready = rdy_q & ~rst;
  assign accept   = in_valid & in_ready;

  // Next-state and bookkeeping; success is tested before timeout so a last ack wins.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    tgrp_d   = tgrp_q;
    cnt_d    = cnt_q;
    pend_nxt = pend_q & ~grp_ack;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        state_d = WAIT_ACK;
        pend_d  = '1;
        tcnt_d  = '0;
      end
      WAIT_ACK: begin
        pend_d = pend_nxt;
        if (pend_nxt == '0) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (tcnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          tgrp_d  = tgrp_q | pend_nxt;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      tgrp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      tgrp_q  <= tgrp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    bcast_grp_reg #(
      .WIDTH(WIDTH)
    ) u_grp (
      .clk1  (clk1),
      .rst   (rst),
      .load  (accept),
      .d     (in_data),
      .q     (grp_data[g*WIDTH +: WIDTH]),
      .valid (grp_valid[g])
    );
  end

  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign timeout_grp = tgrp_q;
  assign bcast_count = cnt_q;

endmodule

// File: tb/tb_fanout_bcast_ctrl.sv
// Directed bench for fanout_bcast_ctrl with a transaction-level timeline model.
module tb_fanout_bcast_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned G = 2;
  localparam int unsigned T = 8;
  localparam int unsigned C = 2;

  logic           clk1 = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [G-1:0]   grp_valid;
  logic [G*W-1:0] grp_data;
  logic [G-1:0]   grp_ack;
  logic           busy;
  logic           timeout_err;
  logic [G-1:0]   timeout_grp;
  logic [C-1:0]   bcast_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic           exp_ready;
  logic           exp_busy;
  logic [G-1:0]   exp_gvalid;
  logic [G*W-1:0] exp_gdata;
  logic           exp_err;
  logic [G-1:0]   exp_tgrp;
  logic [C-1:0]   exp_count;

  always #5 clk1 = ~clk1;

  fanout_bcast_ctrl #(
    .WIDTH   (W),
    .NUM_GRP (G),
    .TIMEOUT (T),
    .CNT_W   (C)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .grp_valid   (grp_valid),
    .grp_data    (grp_data),
    .grp_ack     (grp_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .timeout_grp (timeout_grp),
    .bcast_count (bcast_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare every output to the model on the falling edge.
  always @(negedge clk1) begin
    if (chk_en) begin
      check("in_ready",    32'(in_ready),    32'(exp_ready));
      check("busy",        32'(busy),        32'(exp_busy));
      check("grp_valid",   32'(grp_valid),   32'(exp_gvalid));
      check("grp_data",    32'(grp_data),    32'(exp_gdata));
      check("timeout_err", 32'(timeout_err), 32'(exp_err));
      check("timeout_grp", 32'(timeout_grp), 32'(exp_tgrp));
      check("bcast_count", 32'(bcast_count), 32'(exp_count));
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n, input logic [G-1:0] noise);
    in_valid = 1'b0;
    grp_ack  = noise;
    for (int i = 0; i < n; i++) tick();
    grp_ack = '0;
  endtask

  // One broadcast; offN is the WAIT_ACK cycle on which group N pulses ack (<0 = never).
  // Outcome from the rules: done after max(off)+1 wait cycles if all offsets < T, else after T.
  task automatic txn(input logic [W-1:0] d, input int off0, input int off1, input logic [G-1:0] noise);
    int         off [G];
    int         len;
    int         mx;
    bit         ok;
    logic [G-1:0] never;
    off[0] = off0;
    off[1] = off1;
    ok = 1'b1;
    mx = 0;
    never = '0;
    for (int g = 0; g < G; g++) begin
      if (off[g] < 0 || off[g] >= int'(T)) begin
        ok = 1'b0;
        never[g] = 1'b1;
      end else if (off[g] > mx) begin
        mx = off[g];
      end
    end
    len = ok ? mx + 1 : int'(T);
    in_valid = 1'b1;
    in_data  = d;
    grp_ack  = noise;
    tick();
    exp_ready  = 1'b0;
    exp_busy   = 1'b1;
    exp_gvalid = '1;
    exp_gdata  = {G{d}};
    in_data    = ~d;
    grp_ack    = noise;
    tick();
    exp_gvalid = '0;
    in_valid   = 1'b0;
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < G; g++) grp_ack[g] = (off[g] == k);
      tick();
    end
    grp_ack   = '0;
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
    if (ok) exp_count = exp_count + C'(1);
    else begin
      exp_err  = 1'b1;
      exp_tgrp = exp_tgrp | never;
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    grp_ack    = '0;
    exp_ready  = 1'b0;
    exp_busy   = 1'b0;
    exp_gvalid = '0;
    exp_gdata  = '0;
    exp_err    = 1'b0;
    exp_tgrp   = '0;
    exp_count  = '0;

    @(posedge clk1);
    #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    exp_ready = 1'b1;
    check("lit_reset_count", 32'(bcast_count), 32'd0);
    idle(1, '0);

    // Single broadcast, both groups ack on the first wait cycle.
    txn(4'h5, 0, 0, '0);
    check("lit_single_data",  32'(grp_data),    32'h55);
    check("lit_single_count", 32'(bcast_count), 32'd1);

    // Staggered acks with early acks in IDLE and SEND that must be ignored.
    idle(2, 2'b11);
    txn(4'hA, 2, 5, 2'b11);
    check("lit_stagger_count", 32'(bcast_count), 32'd2);
    check("lit_stagger_err",   32'(timeout_err), 32'd0);

    // Last ack lands on the final allowed wait cycle.
    txn(4'h3, 3, int'(T) - 1, '0);
    check("lit_edge_err",   32'(timeout_err), 32'd0);
    check("lit_edge_count", 32'(bcast_count), 32'd3);

    // Group 1 never acks.
    txn(4'hC, 0, -1, '0);
    check("lit_to_err",   32'(timeout_err), 32'd1);
    check("lit_to_grp",   32'(timeout_grp), 32'h2);
    check("lit_to_count", 32'(bcast_count), 32'd3);

    // Following word completes normally; error stays sticky; counter wraps.
    txn(4'h6, 1, 0, '0);
    check("lit_after_to_err",   32'(timeout_err), 32'd1);
    check("lit_after_to_count", 32'(bcast_count), 32'd0);

    // Reset asserted on wait cycle 2.
    in_valid = 1'b1;
    in_data  = 4'h9;
    tick();
    exp_ready  = 1'b0;
    exp_busy   = 1'b1;
    exp_gvalid = '1;
    exp_gdata  = {G{4'h9}};
    in_valid   = 1'b0;
    tick();
    exp_gvalid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_busy  = 1'b0;
    exp_gdata = '0;
    exp_err   = 1'b0;
    exp_tgrp  = '0;
    exp_count = '0;
    check("lit_rst_busy", 32'(busy),        32'd0);
    check("lit_rst_data", 32'(grp_data),    32'd0);
    check("lit_rst_cnt",  32'(bcast_count), 32'd0);
    check("lit_rst_err",  32'(timeout_err), 32'd0);
    rst = 1'b0;
    exp_ready = 1'b1;

    // Back-to-back words with immediate acks; count runs 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] dv;
      logic [C-1:0] want [5];
      want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
      dv = W'(i * 3 + 1);
      txn(dv, 0, 0, 2'b11);
      check("lit_b2b_count", 32'(bcast_count), 32'(want[i]));
    end

    idle(2, 2'b11);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
